// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the writeback stage.
//   defaultRegSize / defaultDataSize / defaultDepth : default widths and depth.
//   wbEntryT  : one buffered register-file write at the default widths.
//               Fields are dst, data, r15Data and the wr / wrR15 flags.
//   ptrWidth(): pointer width for a ring of n entries. It never returns less
//               than 1, so a single-entry buffer still has a legal pointer.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int defaultRegSize  = 4;
    localparam int defaultDataSize = 16;
    localparam int defaultDepth    = 2;

    typedef struct packed {
        logic [defaultRegSize-1:0]  dst;
        logic [defaultDataSize-1:0] data;
        logic [defaultDataSize-1:0] r15Data;
        logic                       wr;
        logic                       wrR15;
    } wbEntryT;

    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Ring buffer of writeback entries. The buffer also exposes every slot in age
// order, so the forwarding logic can search the entries without knowing the
// pointer positions.
//   clk, rst            : clock and asynchronous active-high reset.
//   push, pushEntry     : write pushEntry at the tail. The caller only pushes
//                         when the buffer is not full.
//   pop                 : drop the head entry. The caller only pops when the
//                         buffer is not empty.
//   full, empty         : occupancy flags.
//   orderedEntry[k]     : entry k in age order. Index 0 is the head (oldest).
//   orderedValid[k]     : orderedEntry[k] holds a live entry.
// -----------------------------------------------------------------------------
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int  depth  = defaultDepth,
    parameter type entryT = wbEntryT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entryT            pushEntry,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output entryT            orderedEntry [depth],
    output logic [depth-1:0] orderedValid
);

    localparam int ptrW = ptrWidth(depth);
    localparam int cntW = $clog2(depth + 1);

    entryT            mem [depth];
    logic [ptrW-1:0]  wrPtr;
    logic [ptrW-1:0]  rdPtr;
    logic [cntW-1:0]  count;

    function automatic logic [ptrW-1:0] nextPtr(input logic [ptrW-1:0] p);
        return (p == ptrW'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: use non-blocking (<=) for every clocked register. Then all flops
    // sample the values from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // NOTE: the storage array has no reset. A slot is only meaningful while
    // count covers it, so clearing the pointers and the count is enough. This
    // also keeps the array mappable to plain RAM or flops without a reset tree.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushEntry;
    end

    assign full  = (count == cntW'(depth));
    assign empty = (count == '0);

    // Age-ordered view. Slot k sits k places after the head and wraps modulo
    // depth.
    // NOTE: every combinational output gets a default at the top of the
    // block. That way no path leaves it unassigned and infers a latch.
    always_comb begin
        orderedValid = '0;
        for (int k = 0; k < depth; k++) begin
            logic [ptrW:0] idx;
            idx = {1'b0, rdPtr} + (ptrW + 1)'(k);
            if (idx >= (ptrW + 1)'(depth)) idx = idx - (ptrW + 1)'(depth);
            orderedEntry[k] = mem[idx[ptrW-1:0]];
            orderedValid[k] = (k < int'(count));
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// -----------------------------------------------------------------------------
// reg_writeback
// A small write buffer between the execute results and the register file. It
// also provides bypass lookups for the decode stage.
//   clk, rst              : clock and asynchronous active-high reset.
//   inValid / inReady     : upstream handshake. inReady depends only on
//                           occupancy, and is low during reset.
//   inDst, inData, inWr   : destination register write.
//   inR15Data, inWrR15    : auxiliary write to register 0.
//   wbHold                : stall the drain into the register file.
//   wr, wrR15, regDst,
//   regDstData, regR15Data: registered register-file write port. The strobes
//                           are high for one cycle per drained entry.
//   regR1, regR2          : decode read addresses.
//   fwdRnHit / fwdRnData  : bypass result. The newest buffered entry wins and
//                           the output register comes last. Zero on a miss.
// -----------------------------------------------------------------------------
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int regSize  = defaultRegSize,
    parameter int dataSize = defaultDataSize,
    parameter int depth    = defaultDepth
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inValid,
    output logic                inReady,
    input  logic [regSize-1:0]  inDst,
    input  logic [dataSize-1:0] inData,
    input  logic                inWr,
    input  logic [dataSize-1:0] inR15Data,
    input  logic                inWrR15,
    input  logic                wbHold,
    output logic                wr,
    output logic                wrR15,
    output logic [regSize-1:0]  regDst,
    output logic [dataSize-1:0] regDstData,
    output logic [dataSize-1:0] regR15Data,
    input  logic [regSize-1:0]  regR1,
    input  logic [regSize-1:0]  regR2,
    output logic                fwdR1Hit,
    output logic                fwdR2Hit,
    output logic [dataSize-1:0] fwdR1Data,
    output logic [dataSize-1:0] fwdR2Data
);

    // Same layout as cpu_pkg::wbEntryT, sized by this instance's parameters.
    typedef struct packed {
        logic [regSize-1:0]  dst;
        logic [dataSize-1:0] data;
        logic [dataSize-1:0] r15Data;
        logic                wr;
        logic                wrR15;
    } entryT;

    entryT            pushEntry;
    entryT            orderedEntry [depth];
    logic [depth-1:0] orderedValid;
    logic             full;
    logic             empty;
    logic             fifoPush;
    logic             fifoPop;

    assign inReady = ~rst & ~full;

    // An entry with neither write flag set is accepted but never stored.
    assign fifoPush = inValid & inReady & (inWr | inWrR15);
    assign fifoPop  = ~empty & ~wbHold;

    // When both writes target register 0, the destination write wins. The
    // auxiliary flag is cleared at entry time, so the drain and the bypass
    // logic never see the conflict.
    always_comb begin
        pushEntry.dst     = inDst;
        pushEntry.data    = inData;
        pushEntry.r15Data = inR15Data;
        pushEntry.wr      = inWr;
        pushEntry.wrR15   = inWrR15 & ~(inWr & (inDst == '0));
    end

    wb_fifo #(
        .depth  (depth),
        .entryT (entryT)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (fifoPush),
        .pushEntry    (pushEntry),
        .pop          (fifoPop),
        .full         (full),
        .empty        (empty),
        .orderedEntry (orderedEntry),
        .orderedValid (orderedValid)
    );

    // Register-file write port. The strobes drop on any cycle with no drain.
    // Address and data hold their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr         <= 1'b0;
            wrR15      <= 1'b0;
            regDst     <= '0;
            regDstData <= '0;
            regR15Data <= '0;
        end else if (fifoPop) begin
            wr         <= orderedEntry[0].wr;
            wrR15      <= orderedEntry[0].wrR15;
            regDst     <= orderedEntry[0].dst;
            regDstData <= orderedEntry[0].data;
            regR15Data <= orderedEntry[0].r15Data;
        end else begin
            wr    <= 1'b0;
            wrR15 <= 1'b0;
        end
    end

    // Bypass search, one copy per read port. Candidates are visited oldest
    // first: output register, then head to tail. A later match overwrites an
    // earlier one, so the newest match wins. Within one entry, a destination
    // match beats the register-0 auxiliary match.
    for (genvar p = 0; p < 2; p++) begin : gFwd
        logic [regSize-1:0]  addr;
        logic                hit;
        logic [dataSize-1:0] data;

        assign addr = (p == 0) ? regR1 : regR2;

        always_comb begin
            hit  = 1'b0;
            data = '0;
            if (wr && regDst == addr) begin
                hit  = 1'b1;
                data = regDstData;
            end else if (wrR15 && addr == '0) begin
                hit  = 1'b1;
                data = regR15Data;
            end
            for (int k = 0; k < depth; k++) begin
                if (orderedValid[k]) begin
                    if (orderedEntry[k].wr && orderedEntry[k].dst == addr) begin
                        hit  = 1'b1;
                        data = orderedEntry[k].data;
                    end else if (orderedEntry[k].wrR15 && addr == '0) begin
                        hit  = 1'b1;
                        data = orderedEntry[k].r15Data;
                    end
                end
            end
        end
    end

    assign fwdR1Hit  = gFwd[0].hit;
    assign fwdR1Data = gFwd[0].data;
    assign fwdR2Hit  = gFwd[1].hit;
    assign fwdR2Data = gFwd[1].data;

endmodule
